cla_adder_reg: RTL and testbench

- Parameterised registered carry-lookahead adder.
- Computes Sum = A + B + Cin with carry-out and signed-overflow flags, and registers the result on the clock.
- Used as a datapath arithmetic leaf; a 4-bit default instance is verified exhaustively over all operand/carry combinations.

---
 rtl/cla_adder_reg.sv | 96 +++++++++
 tb/tb_cla_adder_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cla_adder_reg.sv
// Registered two-level carry-lookahead adder: Sum = A + B + Cin, with carry-out and
// signed-overflow flags, one cycle of latency.
module cla_adder_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);

  localparam int NBLK = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [NBLK-1:0]  bg;
  logic [NBLK-1:0]  bp;
  logic [NBLK:0]    bc;

  assign g     = A & B;
  assign p     = A ^ B;
  assign bc[0] = Cin;

  // First level: 4-bit blocks (the top block may be narrower). Block boundary
  // carries come from the second level, so each block only drives its interior carries.
  for (genvar b = 0; b < NBLK; b++) begin : g_blk
    localparam int LO = 4 * b;
    localparam int BW = (WIDTH - LO < 4) ? (WIDTH - LO) : 4;

    logic [BW-1:0] gt;

    for (genvar j = 0; j < BW; j++) begin : g_gt
      if (j == BW - 1) begin : g_last
        assign gt[j] = g[LO+j];
      end else begin : g_prop
        assign gt[j] = g[LO+j] & (&p[LO+j+1 +: BW-j-1]);
      end
    end

    assign bg[b] = |gt;
    assign bp[b] = &p[LO +: BW];
    assign c[LO] = bc[b];

    for (genvar k = 1; k < BW; k++) begin : g_c
      logic [k-1:0] ct;
      for (genvar j = 0; j < k; j++) begin : g_ct
        if (j == k - 1) begin : g_last
          assign ct[j] = g[LO+j];
        end else begin : g_prop
          assign ct[j] = g[LO+j] & (&p[LO+j+1 +: k-j-1]);
        end
      end
      assign c[LO+k] = (|ct) | (bc[b] & (&p[LO +: k]));
    end
  end

  // Second level: every block carry is a flat sum of products over block G/P and Cin.
  for (genvar b = 0; b < NBLK; b++) begin : g_lvl2
    logic [b+1:0] bt;
    for (genvar j = 0; j <= b; j++) begin : g_bt
      if (j == b) begin : g_last
        assign bt[j] = bg[j];
      end else begin : g_prop
        assign bt[j] = bg[j] & (&bp[j+1 +: b-j]);
      end
    end
    assign bt[b+1]  = Cin & (&bp[0 +: b+1]);
    assign bc[b+1]  = |bt;
  end

  assign c[WIDTH] = bc[NBLK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= p ^ c[WIDTH-1:0];
        Cout <= c[WIDTH];
        Ovf  <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_reg.sv
// Directed and reference-model bench for cla_adder_reg at WIDTH 4, 6 and 1.
module tb_cla_adder_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v4, c4i, co4, ov4, ovd4;
  logic [3:0] a4, b4, s4;
  logic       v6, c6i, co6, ov6, ovd6;
  logic [5:0] a6, b6, s6;
  logic       v1, c1i, co1, ov1, ovd1;
  logic [0:0] a1, b1, s1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  cla_adder_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .A(a4), .B(b4), .Cin(c4i),
    .Sum(s4), .Cout(co4), .Ovf(ov4), .out_valid(ovd4)
  );

  cla_adder_reg #(.WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .A(a6), .B(b6), .Cin(c6i),
    .Sum(s6), .Cout(co6), .Ovf(ov6), .out_valid(ovd6)
  );

  cla_adder_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .Cin(c1i),
    .Sum(s1), .Cout(co1), .Ovf(ov1), .out_valid(ovd1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic [3:0] es, input logic ec, input logic eo);
    a4 = a; b4 = b; c4i = ci; v4 = 1'b1;
    @(negedge clk);
    check({tag, "_sum"},  s4,   es);
    check({tag, "_cout"}, co4,  ec);
    check({tag, "_ovf"},  ov4,  eo);
    check({tag, "_vld"},  ovd4, 1'b1);
  endtask

  initial begin
    logic [4:0] e4;
    logic [6:0] e6;
    logic [1:0] e1;

    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4i = 1'b1;
    v6 = 1'b1; a6 = 6'h3F; b6 = 6'h3F; c6i = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1i = 1'b1;

    // Outputs stay cleared while reset is held, whatever the inputs do.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_sum4", s4, 4'h0);
      check("rst_cout4", co4, 1'b0);
      check("rst_ovf4", ov4, 1'b0);
      check("rst_vld4", ovd4, 1'b0);
      check("rst_sum6", s6, 6'h0);
      check("rst_vld6", ovd6, 1'b0);
      check("rst_sum1", s1, 1'b0);
      check("rst_vld1", ovd1, 1'b0);
      a4 = ~a4;
    end

    a4 = 4'hF;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_sum4", s4, 4'hF);
    check("first_cout4", co4, 1'b1);
    check("first_ovf4", ov4, 1'b0);
    check("first_vld4", ovd4, 1'b1);
    check("first_sum6", s6, 6'h3F);
    check("first_cout6", co6, 1'b1);
    check("first_ovf6", ov6, 1'b0);
    check("first_sum1", s1, 1'b1);
    check("first_cout1", co1, 1'b1);
    check("first_ovf1", ov1, 1'b0);
    v6 = 1'b0;
    v1 = 1'b0;

    // Exhaustive WIDTH=4 sweep, one operand set per cycle.
    for (int i = 0; i < 512; i++) begin
      {a4, b4, c4i} = 9'(i);
      e4 = {1'b0, a4} + {1'b0, b4} + {4'b0, c4i};
      @(negedge clk);
      check("x4_sum", s4, e4[3:0]);
      check("x4_cout", co4, e4[4]);
      check("x4_ovf", ov4, (a4[3] == b4[3]) && (e4[3] != a4[3]));
    end

    apply4("spot_7p1", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    apply4("spot_Fp1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    apply4("spot_FpF", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
    apply4("spot_0p0", 4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0);

    apply4("hold_load", 4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0);
    v4 = 1'b0; a4 = 4'h9; b4 = 4'h9;
    @(negedge clk);
    check("hold_sum_a", s4, 4'h7);
    check("hold_vld_a", ovd4, 1'b0);
    @(negedge clk);
    check("hold_sum_b", s4, 4'h7);
    check("hold_cout_b", co4, 1'b0);

    // Reset asserted between edges must clear outputs before the next edge.
    apply4("pre_rst", 4'h5, 4'h6, 1'b0, 4'hB, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum", s4, 4'h0);
    check("arst_ovf", ov4, 1'b0);
    check("arst_vld", ovd4, 1'b0);
    @(negedge clk);
    check("arst_held_sum", s4, 4'h0);
    rst_n = 1'b1;
    apply4("post_rst", 4'h2, 4'h3, 1'b0, 4'h5, 1'b0, 1'b0);
    v4 = 1'b0;

    // WIDTH=6: partial top block.
    v6 = 1'b1; a6 = 6'h3F; b6 = 6'h01; c6i = 1'b0;
    @(negedge clk);
    check("w6_wrap_sum", s6, 6'h00);
    check("w6_wrap_cout", co6, 1'b1);
    check("w6_wrap_ovf", ov6, 1'b0);
    a6 = 6'h1F; b6 = 6'h01; c6i = 1'b0;
    @(negedge clk);
    check("w6_ovf_sum", s6, 6'h20);
    check("w6_ovf_cout", co6, 1'b0);
    check("w6_ovf_ovf", ov6, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      a6 = 6'($urandom);
      b6 = 6'($urandom);
      c6i = 1'($urandom);
      e6 = {1'b0, a6} + {1'b0, b6} + {6'b0, c6i};
      @(negedge clk);
      check("w6_rnd_sum", s6, e6[5:0]);
      check("w6_rnd_cout", co6, e6[6]);
      check("w6_rnd_ovf", ov6, (a6[5] == b6[5]) && (e6[5] != a6[5]));
    end
    v6 = 1'b0;

    // WIDTH=1: registered full adder.
    v1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1i} = 3'(i);
      e1 = {1'b0, a1} + {1'b0, b1} + {1'b0, c1i};
      @(negedge clk);
      check("w1_sum", s1, a1 ^ b1 ^ c1i);
      check("w1_cout", co1, (a1 & b1) | (a1 & c1i) | (b1 & c1i));
      check("w1_ovf", ov1, e1[1] ^ c1i);
      check("w1_vld", ovd1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
